up_timer: RTL and testbench
===========================

Name: up_timer

Overview:
Programmable up-counting timer, the incrementing counterpart of the team's existing decrement-to-zero countdown datapath (subtractor + equality compare + enable flops).
- Latches a limit on Start, counts up from 0, compares against the limit each cycle, and pulses Done on match.
- Supports pause, abort and periodic (auto-restart) operation.
- Sits beside the countdown logic in the lab datapath as the event/interval generator.

Parameters:
N, 5, width of Limit, the internal limit register and Count.

Ports:
Clk  input  1  system clock; all state changes on posedge.
Reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
Start  input  1  begin a timing run; sampled only in IDLE.
Limit  input  N  terminal count; latched on the accepted Start edge.
Pause  input  1  1 = hold Count (and any match) in RUN.
Periodic  input  1  1 = on match restart from 0 instead of going IDLE; sampled at the match edge.
Abort  input  1  terminate the run with no Done; highest priority.
Busy  output  1  1 while in RUN.
Count  output  N  current count, registered.
Done  output  1  one-cycle registered pulse on match.

Behaviour:
Reset
- Reset=0, asynchronous: state=IDLE, Count=0, LimitReg=0, Busy=0, Done=0.
- Takes effect immediately, including mid-run. No Done is generated by reset.

States
- Two states, IDLE and RUN. Busy = (state==RUN), registered.
- Done defaults to 0 every edge unless set by a match.

IDLE
- Start=1 and Abort=0 at an edge: LimitReg<=Limit, Count<=0, state<=RUN.
- Otherwise: Count holds its last value, which is the final count of the previous run.

RUN, per edge, in priority order:
1. Abort=1: state<=IDLE, Count holds, Done stays 0.
2. Pause=1: everything holds, including when Count==LimitReg.
3. Count==LimitReg (N-bit equality):
   - Done<=1.
   - Periodic=1: Count<=0, stay in RUN.
   - Periodic=0: state<=IDLE, Count holds at LimitReg.
4. Otherwise: Count<=Count+1.

Timing and limits
- Latency: Start accepted at edge e0 gives Count=k after edge e0+k. With no pause, Done=1 and Busy=0 in the cycle after edge e0+L+1, so Start-to-Done is L+1 cycles.
- Each Pause cycle adds one cycle.
- Periodic period = L+1 cycles.
- Limit=0: Done follows 1 cycle after Count=0 and is valid.
- Limit=2^N-1: Count reaches all-ones; never wraps, because the compare precedes the increment.

Input rules
- Start while in RUN is ignored.
- Limit changes during RUN are ignored; LimitReg is used.
- Start and Abort in the same IDLE cycle: Abort wins, so Start is ignored.
- Periodic is only relevant at the match edge.

Test Plan:
1. Reset=0 pulsed mid-run at Count=3 -> Count=0, Busy=0, Done=0 immediately (before next Clk edge); no Done afterwards.
2. N=5, Start with Limit=6, Pause=0 -> Count 0..6 on successive cycles; Done=1 exactly one cycle, 7 cycles after Start edge; Busy falls same cycle; Count stays 6.
3. Limit=4, Pause=1 for 3 cycles at Count=2 -> Count holds at 2; Done arrives 8 cycles after Start; Start pulsed mid-run and Limit changed to 9 -> no effect.
4. Limit=3, Periodic=1 -> Done pulses every 4 cycles, Count sequence 0,1,2,3,0,1..., Busy constant 1; drop Periodic -> next match ends in IDLE with Count=3.
5. Limit=0 -> Done 1 cycle after Start edge; Limit=31 -> Count reaches 31 without wrap, Done after 32 cycles.
6. Abort at Count=5 of Limit=10 -> IDLE next edge, Count=5, no Done; Start+Abort together in IDLE -> stays IDLE.

Source files
------------

// File: rtl/up_timer.sv
// Programmable up-counting timer: latches a limit on Start, counts up from 0 and pulses Done
// when the count matches the limit. Supports pause, abort and periodic auto-restart.
module up_timer #(
    parameter int unsigned N = 5
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [N-1:0] Limit,
    input  logic         Pause,
    input  logic         Periodic,
    input  logic         Abort,
    output logic         Busy,
    output logic [N-1:0] Count,
    output logic         Done
);

    typedef enum logic {
        StIdle,
        StRun
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] count_q, count_d;
    logic [N-1:0] limit_q, limit_d;
    logic         done_q, done_d;

    // Next-state: abort beats pause, pause beats the match, and the match beats the increment,
    // so the count never wraps past the limit.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        limit_d = limit_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (Start && !Abort) begin
                    limit_d = Limit;
                    count_d = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (Abort) begin
                    state_d = StIdle;
                end else if (Pause) begin
                    // hold everything, including a pending match
                end else if (count_q == limit_q) begin
                    done_d = 1'b1;
                    if (Periodic) begin
                        count_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    count_d = count_q + N'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= StIdle;
            count_q <= '0;
            limit_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            limit_q <= limit_d;
            done_q  <= done_d;
        end
    end

    assign Busy  = (state_q == StRun);
    assign Count = count_q;
    assign Done  = done_q;

endmodule

// File: tb/tb_up_timer.sv
// Self-checking bench for up_timer: hand-derived vector table fed through a scoreboard queue,
// plus a hand-written asynchronous reset sequence.
module tb_up_timer;

    localparam int unsigned N = 5;

    typedef struct packed {
        logic         start;
        logic [N-1:0] limit;
        logic         pause;
        logic         periodic;
        logic         abort;
        logic         busy;
        logic [N-1:0] count;
        logic         done;
    } vec_t;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         Start;
    logic [N-1:0] Limit;
    logic         Pause;
    logic         Periodic;
    logic         Abort;
    logic         Busy;
    logic [N-1:0] Count;
    logic         Done;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    up_timer #(.N(N)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .Limit    (Limit),
        .Pause    (Pause),
        .Periodic (Periodic),
        .Abort    (Abort),
        .Busy     (Busy),
        .Count    (Count),
        .Done     (Done)
    );

    always #5 Clk = ~Clk;

    function automatic void add(input logic s, input logic [N-1:0] l, input logic p,
                                input logic per, input logic a, input logic b,
                                input logic [N-1:0] c, input logic d);
        vec_t v;
        v.start = s; v.limit = l; v.pause = p; v.periodic = per; v.abort = a;
        v.busy = b; v.count = c; v.done = d;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic b, input logic [N-1:0] c,
                         input logic d);
        n_vec++;
        if (Busy !== b || Count !== c || Done !== d) begin
            n_err++;
            $display("FAIL %s: got busy=%0b count=%0d done=%0b, want busy=%0b count=%0d done=%0b",
                     name, Busy, Count, Done, b, c, d);
        end
    endtask

    task automatic idle_inputs();
        Start = 1'b0; Limit = '0; Pause = 1'b0; Periodic = 1'b0; Abort = 1'b0;
    endtask

    initial begin
        vec_t v;
        vec_t e;

        // Limit=6: count 0..6, Done 7 edges after Start, Count stays 6.
        add(1, 5'd6, 0, 0, 0, 1, 5'd0, 0);
        for (int k = 1; k <= 6; k++) add(0, 5'd0, 0, 0, 0, 1, k[N-1:0], 0);
        add(0, 5'd0, 0, 0, 0, 0, 5'd6, 1);
        add(0, 5'd0, 0, 0, 0, 0, 5'd6, 0);
        // Limit=4, pause 3 cycles at 2, Start/Limit=9 mid-run ignored; Done 8 edges after Start.
        add(1, 5'd4, 0, 0, 0, 1, 5'd0, 0);
        add(0, 5'd0, 0, 0, 0, 1, 5'd1, 0);
        add(0, 5'd0, 0, 0, 0, 1, 5'd2, 0);
        add(0, 5'd0, 1, 0, 0, 1, 5'd2, 0);
        add(1, 5'd9, 1, 0, 0, 1, 5'd2, 0);
        add(0, 5'd9, 1, 0, 0, 1, 5'd2, 0);
        add(0, 5'd9, 0, 0, 0, 1, 5'd3, 0);
        add(1, 5'd9, 0, 0, 0, 1, 5'd4, 0);
        add(0, 5'd9, 0, 0, 0, 0, 5'd4, 1);
        add(0, 5'd0, 0, 0, 0, 0, 5'd4, 0);
        // Limit=3 periodic: Done every 4 edges; Periodic dropped at the third match.
        add(1, 5'd3, 0, 1, 0, 1, 5'd0, 0);
        for (int r = 0; r < 2; r++) begin
            for (int k = 1; k <= 3; k++) add(0, 5'd0, 0, 1, 0, 1, k[N-1:0], 0);
            add(0, 5'd0, 0, 1, 0, 1, 5'd0, 1);
        end
        for (int k = 1; k <= 3; k++) add(0, 5'd0, 0, 1, 0, 1, k[N-1:0], 0);
        add(0, 5'd0, 0, 0, 0, 0, 5'd3, 1);
        add(0, 5'd0, 0, 0, 0, 0, 5'd3, 0);
        // Limit=0: Done one edge after Count=0.
        add(1, 5'd0, 0, 0, 0, 1, 5'd0, 0);
        add(0, 5'd0, 0, 0, 0, 0, 5'd0, 1);
        add(0, 5'd0, 0, 0, 0, 0, 5'd0, 0);
        // Limit=31: reaches all-ones without wrap, Done 32 edges after Start.
        add(1, 5'd31, 0, 0, 0, 1, 5'd0, 0);
        for (int k = 1; k <= 31; k++) add(0, 5'd0, 0, 0, 0, 1, k[N-1:0], 0);
        add(0, 5'd0, 0, 0, 0, 0, 5'd31, 1);
        add(0, 5'd0, 0, 0, 0, 0, 5'd31, 0);
        // Pause held while Count==Limit suppresses the match.
        add(1, 5'd2, 0, 0, 0, 1, 5'd0, 0);
        add(0, 5'd0, 0, 0, 0, 1, 5'd1, 0);
        add(0, 5'd0, 0, 0, 0, 1, 5'd2, 0);
        add(0, 5'd0, 1, 0, 0, 1, 5'd2, 0);
        add(0, 5'd0, 1, 0, 0, 1, 5'd2, 0);
        add(0, 5'd0, 0, 0, 0, 0, 5'd2, 1);
        // Abort at Count=5 of Limit=10: no Done, Count holds; Start+Abort in IDLE ignored.
        add(1, 5'd10, 0, 0, 0, 1, 5'd0, 0);
        for (int k = 1; k <= 5; k++) add(0, 5'd0, 0, 0, 0, 1, k[N-1:0], 0);
        add(0, 5'd0, 0, 0, 1, 0, 5'd5, 0);
        add(0, 5'd0, 0, 0, 0, 0, 5'd5, 0);
        add(1, 5'd7, 0, 0, 1, 0, 5'd5, 0);
        add(0, 5'd0, 0, 0, 0, 0, 5'd5, 0);

        idle_inputs();
        Reset = 1'b0;
        #12;
        check("reset_state", 1'b0, 5'd0, 1'b0);
        @(negedge Clk);
        Reset = 1'b1;

        // Asynchronous reset mid-run at Count=3.
        @(negedge Clk);
        Start = 1'b1; Limit = 5'd6;
        @(negedge Clk);
        idle_inputs();
        repeat (3) @(negedge Clk);
        check("run_to_3", 1'b1, 5'd3, 1'b0);
        #2;
        Reset = 1'b0;
        #1;
        check("async_reset", 1'b0, 5'd0, 1'b0);
        @(negedge Clk);
        Reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge Clk);
            check("post_reset_quiet", 1'b0, 5'd0, 1'b0);
        end

        // Table: drive at negedge, push expectation, pop and compare just after the edge.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge Clk);
            v = vecs[i];
            Start = v.start; Limit = v.limit; Pause = v.pause;
            Periodic = v.periodic; Abort = v.abort;
            exp_q.push_back(v);
            @(posedge Clk);
            #1;
            e = exp_q.pop_front();
            check($sformatf("vec%0d", i), e.busy, e.count, e.done);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
